// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if
//   Groups the request, FPU and result signals around the FPU op sequencer.
//   master : stimulus / FPU / consumer side (drives requests, fpu_out, res_ready)
//   slave  : the sequencer (drives in_ready, fpu_*, res_*, busy)
//   Request : in_valid, in_ready, in_opA, in_opB, in_op
//   FPU     : fpu_valid, fpu_opA, fpu_opB, fpu_op (to FPU), fpu_out (from FPU)
//   Result  : res_valid, res_ready, res_data, res_op, res_tag
//   Status  : busy
interface fpu_op_sequencer_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_opA;
    logic [31:0]      in_opB;
    logic [1:0]       in_op;
    logic             fpu_valid;
    logic [31:0]      fpu_opA;
    logic [31:0]      fpu_opB;
    logic [1:0]       fpu_op;
    logic [31:0]      fpu_out;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [1:0]       res_op;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    modport master (
        output in_valid, in_opA, in_opB, in_op, fpu_out, res_ready,
        input  in_ready, fpu_valid, fpu_opA, fpu_opB, fpu_op,
               res_valid, res_data, res_op, res_tag, busy
    );

    modport slave (
        input  in_valid, in_opA, in_opB, in_op, fpu_out, res_ready,
        output in_ready, fpu_valid, fpu_opA, fpu_opB, fpu_op,
               res_valid, res_data, res_op, res_tag, busy
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Issue and capture stage around a fixed-latency pipelined FPU. Requests are
//   buffered in a request FIFO, issued one per cycle when result FIFO credit is
//   available, tracked through a valid/op/tag pipe matching the FPU latency, and
//   the FPU result is captured into a result FIFO with its op and sequence tag.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : fpu_op_sequencer_if.slave (request, FPU and result handshakes, busy)

// Checker: result FIFO must never be written while full.
module fpu_op_sequencer_chk #(
    parameter int OUT_CW    = 3,
    parameter int OUT_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    input logic              cap,
    input logic [OUT_CW-1:0] out_count
);
    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(cap && (out_count == OUT_FULL)));
endmodule

module fpu_op_sequencer #(
    parameter int LATENCY   = 4,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TAG_W     = 8
) (
    input logic               clk,
    input logic               reset,
    fpu_op_sequencer_if.slave bus
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_CW = OUT_AW + 1;
    localparam logic [IN_CW-1:0]  IN_FULL   = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW:0]   OUT_LIMIT = (OUT_CW + 1)'(OUT_DEPTH);

    // Request FIFO
    logic [31:0]       in_a_mem_r   [IN_DEPTH];
    logic [31:0]       in_b_mem_r   [IN_DEPTH];
    logic [1:0]        in_op_mem_r  [IN_DEPTH];
    logic [TAG_W-1:0]  in_tag_mem_r [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_r;
    logic [IN_AW-1:0]  in_rd_r;
    logic [IN_CW-1:0]  in_count_r;
    logic [TAG_W-1:0]  tag_cnt_r;

    // Issue registers (pipe stage 0) and latency pipe (stages 1..LATENCY)
    logic              fpu_valid_r;
    logic [31:0]       fpu_opa_r;
    logic [31:0]       fpu_opb_r;
    logic [1:0]        fpu_op_r;
    logic [TAG_W-1:0]  fpu_tag_r;
    logic              pipe_v_r   [1:LATENCY];
    logic [1:0]        pipe_op_r  [1:LATENCY];
    logic [TAG_W-1:0]  pipe_tag_r [1:LATENCY];

    // Result FIFO and credit tracking
    logic [31:0]       out_data_mem_r [OUT_DEPTH];
    logic [1:0]        out_op_mem_r   [OUT_DEPTH];
    logic [TAG_W-1:0]  out_tag_mem_r  [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_r;
    logic [OUT_AW-1:0] out_rd_r;
    logic [OUT_CW-1:0] out_count_r;
    logic [OUT_CW-1:0] inflight_r;

    logic              in_ready_s;
    logic              push_s;
    logic              issue_s;
    logic              cap_s;
    logic              pop_s;
    logic [OUT_CW:0]   credit_used_s;

    // Handshake and issue decisions, all from registered state (reset only gates in_ready).
    always_comb begin
        in_ready_s    = (!reset) && (in_count_r < IN_FULL);
        push_s        = bus.in_valid && in_ready_s;
        // Result slots are reserved at issue, so capture can never find the FIFO full.
        credit_used_s = {1'b0, inflight_r} + {1'b0, out_count_r};
        issue_s       = (in_count_r != '0) && (credit_used_s < OUT_LIMIT);
        cap_s         = pipe_v_r[LATENCY];
        pop_s         = (out_count_r != '0) && bus.res_ready;
    end

    // Request FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            in_a_mem_r[in_wr_r]   <= bus.in_opA;
            in_b_mem_r[in_wr_r]   <= bus.in_opB;
            in_op_mem_r[in_wr_r]  <= bus.in_op;
            in_tag_mem_r[in_wr_r] <= tag_cnt_r;
        end
    end

    // Request FIFO pointers, occupancy and tag counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_r    <= '0;
            in_rd_r    <= '0;
            in_count_r <= '0;
            tag_cnt_r  <= '0;
        end else begin
            if (push_s) begin
                in_wr_r   <= in_wr_r + IN_AW'(1);
                tag_cnt_r <= tag_cnt_r + TAG_W'(1);
            end
            if (issue_s) begin
                in_rd_r <= in_rd_r + IN_AW'(1);
            end
            in_count_r <= in_count_r + IN_CW'(push_s) - IN_CW'(issue_s);
        end
    end

    // Issue registers toward the FPU; operands hold when nothing is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_valid_r <= 1'b0;
            fpu_opa_r   <= 32'd0;
            fpu_opb_r   <= 32'd0;
            fpu_op_r    <= 2'd0;
            fpu_tag_r   <= '0;
        end else begin
            fpu_valid_r <= issue_s;
            if (issue_s) begin
                fpu_opa_r <= in_a_mem_r[in_rd_r];
                fpu_opb_r <= in_b_mem_r[in_rd_r];
                fpu_op_r  <= in_op_mem_r[in_rd_r];
                fpu_tag_r <= in_tag_mem_r[in_rd_r];
            end
        end
    end

    // Latency pipe; stage LATENCY lines up with fpu_out of the matching issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_v_r[i]   <= 1'b0;
                pipe_op_r[i]  <= 2'd0;
                pipe_tag_r[i] <= '0;
            end
        end else begin
            pipe_v_r[1]   <= fpu_valid_r;
            pipe_op_r[1]  <= fpu_op_r;
            pipe_tag_r[1] <= fpu_tag_r;
            for (int i = 2; i <= LATENCY; i++) begin
                pipe_v_r[i]   <= pipe_v_r[i-1];
                pipe_op_r[i]  <= pipe_op_r[i-1];
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
        end
    end

    // Result FIFO storage; cleared on reset so the result outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                out_data_mem_r[i] <= 32'd0;
                out_op_mem_r[i]   <= 2'd0;
                out_tag_mem_r[i]  <= '0;
            end
        end else if (cap_s) begin
            out_data_mem_r[out_wr_r] <= bus.fpu_out;
            out_op_mem_r[out_wr_r]   <= pipe_op_r[LATENCY];
            out_tag_mem_r[out_wr_r]  <= pipe_tag_r[LATENCY];
        end
    end

    // Result FIFO pointers, occupancy and in-flight count.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_r    <= '0;
            out_rd_r    <= '0;
            out_count_r <= '0;
            inflight_r  <= '0;
        end else begin
            if (cap_s) begin
                out_wr_r <= out_wr_r + OUT_AW'(1);
            end
            if (pop_s) begin
                out_rd_r <= out_rd_r + OUT_AW'(1);
            end
            out_count_r <= out_count_r + OUT_CW'(cap_s) - OUT_CW'(pop_s);
            inflight_r  <= inflight_r + OUT_CW'(issue_s) - OUT_CW'(cap_s);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.fpu_valid = fpu_valid_r;
    assign bus.fpu_opA   = fpu_opa_r;
    assign bus.fpu_opB   = fpu_opb_r;
    assign bus.fpu_op    = fpu_op_r;
    assign bus.res_valid = (out_count_r != '0);
    assign bus.res_data  = out_data_mem_r[out_rd_r];
    assign bus.res_op    = out_op_mem_r[out_rd_r];
    assign bus.res_tag   = out_tag_mem_r[out_rd_r];
    assign bus.busy      = (in_count_r != '0) || (inflight_r != '0) || (out_count_r != '0);

    fpu_op_sequencer_chk #(
        .OUT_CW    (OUT_CW),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .cap       (cap_s),
        .out_count (out_count_r)
    );
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Testbench for fpu_op_sequencer. Two instances: u0 (OUT_DEPTH=4, TAG_W=8) for
// single-op timing, backpressure and mid-flight reset; u1 (OUT_DEPTH=8, TAG_W=2)
// for streaming and tag wrap. A stub FPU adds the operands with LATENCY delay and
// a queue-based reference model predicts every popped result.
module tb_fpu_op_sequencer;
    localparam int LAT = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpu_op_sequencer_if #(.TAG_W(8)) b0 ();
    fpu_op_sequencer_if #(.TAG_W(2)) b1 ();

    fpu_op_sequencer #(.LATENCY(LAT), .IN_DEPTH(4), .OUT_DEPTH(4), .TAG_W(8)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    fpu_op_sequencer #(.LATENCY(LAT), .IN_DEPTH(4), .OUT_DEPTH(8), .TAG_W(2)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    // Stub FPU: integer sum of the presented operands, valid LAT cycles later.
    logic [31:0] fp0 [LAT];
    logic [31:0] fp1 [LAT];
    always @(posedge clk) begin
        fp0[0] <= b0.fpu_opA + b0.fpu_opB;
        fp1[0] <= b1.fpu_opA + b1.fpu_opB;
        for (int i = 1; i < LAT; i++) begin
            fp0[i] <= fp0[i-1];
            fp1[i] <= fp1[i-1];
        end
    end
    assign b0.fpu_out = fp0[LAT-1];
    assign b1.fpu_out = fp1[LAT-1];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Reference model: every accepted request yields one result, in order,
    // data = opA + opB, same op, tag = acceptance index mod 2^TAG_W.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
        logic [7:0]  tag;
    } exp_t;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [1:0]  tags1[$];
    int          tag0, tag1, issued0;
    logic [7:0]  last_tag0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            q0.delete(); q1.delete(); tags1.delete();
            tag0 = 0; tag1 = 0;
        end else begin
            if (b0.fpu_valid) issued0++;
            if (b0.res_valid && b0.res_ready) begin
                chk("u0_result_expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("u0_res_data", b0.res_data, e.data);
                    chk("u0_res_op", 32'(b0.res_op), 32'(e.op));
                    chk("u0_res_tag", 32'(b0.res_tag), 32'(e.tag));
                    last_tag0 = b0.res_tag;
                end
            end
            if (b0.in_valid && b0.in_ready) begin
                e.data = b0.in_opA + b0.in_opB; e.op = b0.in_op; e.tag = 8'(tag0);
                q0.push_back(e);
                tag0 = (tag0 + 1) % 256;
            end
            if (b1.res_valid && b1.res_ready) begin
                chk("u1_result_expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("u1_res_data", b1.res_data, e.data);
                    chk("u1_res_op", 32'(b1.res_op), 32'(e.op));
                    chk("u1_res_tag", 32'(b1.res_tag), 32'(e.tag));
                    tags1.push_back(b1.res_tag);
                end
            end
            if (b1.in_valid && b1.in_ready) begin
                e.data = b1.in_opA + b1.in_opB; e.op = b1.in_op; e.tag = 8'(tag1);
                q1.push_back(e);
                tag1 = (tag1 + 1) % 4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) begin
            b0.in_valid = v; b0.in_opA = $urandom; b0.in_opB = $urandom;
            b0.in_op = 2'($urandom_range(0, 3));
        end else begin
            b1.in_valid = v; b1.in_opA = $urandom; b1.in_opB = $urandom;
            b1.in_op = 2'($urandom_range(0, 3));
        end
    endtask

    // Push n random requests, waiting (bounded) for in_ready on each.
    task automatic push(input int sel, input int n);
        int   w;
        logic rdy;
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b1);
            w = 0;
            @(negedge clk);
            rdy = (sel == 0) ? b0.in_ready : b1.in_ready;
            while (!rdy && w < 50) begin
                step();
                @(negedge clk);
                rdy = (sel == 0) ? b0.in_ready : b1.in_ready;
                w++;
            end
            chk("push_accept_timeout", 32'(rdy), 32'd1);
            step();
        end
        if (sel == 0) b0.in_valid = 1'b0; else b1.in_valid = 1'b0;
    endtask

    task automatic drain(input int sel);
        int   w;
        logic bsy;
        w = 0;
        bsy = (sel == 0) ? b0.busy : b1.busy;
        while (bsy !== 1'b0 && w < 200) begin
            step();
            bsy = (sel == 0) ? b0.busy : b1.busy;
            w++;
        end
        chk("drain_busy", 32'(bsy), 32'd0);
        step();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          base, first, last, nrv;
        logic [1:0]  exp_tags [6];
        exp_tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n_cmp = 0; n_err = 0; issued0 = 0; last_tag0 = 8'hFF;
        reset = 1'b1;
        b0.in_valid = 1'b0; b0.in_opA = 32'd0; b0.in_opB = 32'd0; b0.in_op = 2'd0; b0.res_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_opA = 32'd0; b1.in_opB = 32'd0; b1.in_op = 2'd0; b1.res_ready = 1'b0;
        step(); step();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(b0.in_ready), 32'd0);
        chk("rst_fpu_valid", 32'(b0.fpu_valid), 32'd0);
        chk("rst_fpu_opA", b0.fpu_opA, 32'd0);
        chk("rst_res_valid", 32'(b0.res_valid), 32'd0);
        chk("rst_res_data", b0.res_data, 32'd0);
        chk("rst_res_tag", 32'(b0.res_tag), 32'd0);
        chk("rst_busy", 32'(b0.busy), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(b0.in_ready), 32'd1);

        // Single op: cycle 0 accept, fpu_valid only in cycle 2, res_valid in cycle 7
        b0.in_valid = 1'b1; b0.in_opA = 32'h3F800000; b0.in_opB = 32'h40000000; b0.in_op = 2'd2;
        b0.res_ready = 1'b1;
        step();
        b0.in_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("single_fpu_valid", 32'(b0.fpu_valid), 32'(c == 2));
            chk("single_res_valid", 32'(b0.res_valid), 32'(c == 7));
            chk("single_busy", 32'(b0.busy), 32'(c <= 7));
            if (c == 7) begin
                chk("single_res_data", b0.res_data, 32'h7F800000);
                chk("single_res_op", 32'(b0.res_op), 32'd2);
                chk("single_res_tag", 32'(b0.res_tag), 32'd0);
            end
            step();
        end

        // Backpressure: 8 accepted, only 4 issued, 9th stalls until credit returns
        b0.res_ready = 1'b0;
        base = issued0;
        push(0, 8);
        drive(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready_full", 32'(b0.in_ready), 32'd0);
            chk("bp_res_valid", 32'(b0.res_valid), 32'd1);
            chk("bp_hold_data", b0.res_data, q0[0].data);
            step();
        end
        chk("bp_issued", 32'(issued0 - base), 32'd4);
        b0.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_R0", 32'(b0.in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("bp_ready_issue_pop", 32'(b0.in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("bp_ready_after_pop", 32'(b0.in_ready), 32'd1);
        step();
        b0.in_valid = 1'b0;
        drain(0);
        chk("bp_all_delivered", 32'(q0.size()), 32'd0);

        // Reset with ops queued and in flight
        push(0, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(b0.in_ready), 32'd1);
        chk("mid_rst_fpu_valid", 32'(b0.fpu_valid), 32'd0);
        chk("mid_rst_fpu_opB", b0.fpu_opB, 32'd0);
        chk("mid_rst_fpu_op", 32'(b0.fpu_op), 32'd0);
        chk("mid_rst_res_valid", 32'(b0.res_valid), 32'd0);
        chk("mid_rst_res_data", b0.res_data, 32'd0);
        chk("mid_rst_busy", 32'(b0.busy), 32'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("late_fpu_out_ignored", 32'(b0.res_valid), 32'd0);
            step();
        end
        push(0, 1);
        drain(0);
        chk("tag_after_reset", 32'(last_tag0), 32'd0);

        // Streaming on u1: 20 back-to-back requests, 20 consecutive results
        b1.res_ready = 1'b1;
        first = -1; last = -1; nrv = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1, (c < 20));
            @(negedge clk);
            if (c < 20) chk("stream_in_ready", 32'(b1.in_ready), 32'd1);
            if (b1.res_valid) begin
                nrv++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        b1.in_valid = 1'b0;
        chk("stream_rv_count", 32'(nrv), 32'd20);
        chk("stream_first_rv", 32'(first), 32'd7);
        chk("stream_contiguous", 32'(last - first + 1), 32'd20);
        chk("stream_all_delivered", 32'(q1.size()), 32'd0);

        // Tag wrap on u1 (TAG_W=2)
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(1, 6);
        drain(1);
        chk("wrap_count", 32'(tags1.size()), 32'd6);
        if (tags1.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("wrap_tag", 32'(tags1[i]), 32'(exp_tags[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Upstream issue and downstream capture stage around the pipelined FPU.
- Buffers operand requests (opA, opB, 2-bit op) from the stimulus side and issues them to the FPU at one per cycle.
- Tracks in-flight operations against the fixed FPU latency and captures fpu_out into a result FIFO with the original op and a sequence tag.
- Uses credits so results are never dropped when the consumer stalls.

Parameters:
- LATENCY, 4: FPU latency in cycles; fpu_out for operands presented in cycle k is valid in cycle k+LATENCY; must be ≥1.
- IN_DEPTH, 4: request FIFO entries; power of 2.
- OUT_DEPTH, 4: result FIFO entries; power of 2.
- TAG_W, 8: sequence tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at posedge
- in_opA  in  32  operand A, IEEE-754 single
- in_opB  in  32  operand B
- in_op  in  2  operation code, passed through unmodified
- fpu_valid  out  1  fpu_opA/fpu_opB/fpu_op are valid this cycle
- fpu_opA  out  32  registered operand A to FPU
- fpu_opB  out  32  registered operand B to FPU
- fpu_op  out  2  registered op to FPU
- fpu_out  in  32  FPU result
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  consumer pops on res_valid && res_ready
- res_data  out  32  captured fpu_out
- res_op  out  2  op of that result
- res_tag  out  TAG_W  sequence tag of that result
- busy  out  1  any entry in either FIFO or in flight

Behaviour:
- Reset (clk edge with reset=1): FIFO pointers/counts, in-flight count, valid pipe and tag counter go to 0. fpu_valid=0, fpu_opA/fpu_opB/fpu_op=0, res_valid=0, res_data/res_op/res_tag=0, busy=0, in_ready=0 while reset is high. Reset mid-operation discards all queued and in-flight ops; fpu_out arriving later is ignored. in_ready=1 in the first cycle after reset deasserts.
- in_ready = (in_count < IN_DEPTH), from the registered count only. A pop in the same cycle does not allow a push into a full FIFO. No combinational path from res_ready to in_ready.
- Tag: the accepted request gets the current tag counter; the counter increments per accept and wraps modulo 2^TAG_W.
- Issue condition (registered state only): in_count > 0 && (inflight + out_count) < OUT_DEPTH.
  - On issue: pop head; next cycle fpu_valid=1 with its operands. Otherwise fpu_valid=0 and fpu_op* hold their last values.
  - A request pushed in cycle t is issued no earlier than cycle t+1.
- Valid/tag/op shift pipe, LATENCY+1 stages, aligned to fpu_valid. fpu_out is written into the result FIFO at the end of cycle k+LATENCY for fpu_valid in cycle k.
- inflight: increments on issue, decrements on capture; both can happen in the same cycle (net 0).
- Credits: result FIFO space is reserved at issue, so capture never sees a full FIFO. Overflow is a design error and must be guarded by an assertion. A res pop frees credit visible the next cycle.
- Result FIFO: res_valid = (out_count != 0). res_data/res_op/res_tag must be stable while res_valid && !res_ready. Capture and pop in the same cycle are both legal.
- Minimum latency: accept at end of cycle t → fpu_valid in t+2 → res_valid in t+3+LATENCY.
- Ordering is strictly FIFO end to end.
- Throughput is 1 op/cycle sustained when res_ready=1 and OUT_DEPTH ≥ LATENCY+2.
- busy = in_count != 0 || inflight != 0 || out_count != 0.

Test Plan:
- Bench stub FPU: fpu_out = fpu_opA + fpu_opB (integer) delayed LATENCY cycles.
- Single op (LATENCY=4): accept opA=3F800000, opB=40000000, op=2 in cycle 0 → fpu_valid only in cycle 2 → res_valid in cycle 7 with res_data=7F800000, res_op=2, res_tag=0; busy falls after the pop.
- Backpressure (res_ready=0): push 8 ops → exactly 4 issued (credits); in_ready=0 after 4 more accepted; 9th stalled. Raise res_ready → tags 0..7 in order with correct sums, none lost or duplicated.
- Streaming (res_ready=1, OUT_DEPTH=8): 20 back-to-back requests → in_valid&&in_ready every cycle, 20 consecutive res_valid cycles, tags 0..19.
- Reset mid-flight: 3 ops in flight, 2 queued, reset 1 cycle → next cycle all outputs 0, busy=0; late fpu_out values are never captured; next accepted op gets tag 0.
- Tag wrap (TAG_W=2): 6 ops → res_tag sequence 0,1,2,3,0,1.
- Simultaneous events: with in FIFO full, hold in_valid=1 while an issue pops → no push that cycle, push next cycle; capture and res pop in the same cycle keep out_count unchanged.
